uart_tx_arbiter: RTL and testbench

Shares the single UART transmit byte stream (user tx valid/ready/data into the UART core) between P_NUM_REQ requesters, for example the AXI-Lite register path, a debug/log engine and a DMA-style packet source.
Arbitration is round-robin at packet granularity. A granted requester keeps the stream until it sends its last byte or hits the burst limit.
Sits between the requesters and the UART core's user tx interface, in the S_AXI_ACLK domain.

---
 rtl/uart_tx_arbiter.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing the UART user tx byte stream.
// Optional per-grant tag byte {4'hA, grant index} enabled by defining UART_ARB_TAG_EN.
module uart_tx_arbiter #(
  parameter int P_NUM_REQ    = 4,
  parameter int P_DATA_WIDTH = 8,
  parameter int P_MAX_BURST  = 16
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [P_NUM_REQ-1:0]              i_req_valid,
  input  logic [P_NUM_REQ*P_DATA_WIDTH-1:0] i_req_data,
  input  logic [P_NUM_REQ-1:0]              i_req_last,
  output logic [P_NUM_REQ-1:0]              o_req_ready,
  output logic                              o_user_tx_valid,
  output logic [P_DATA_WIDTH-1:0]           o_user_tx_data,
  input  logic                              i_user_tx_ready,
  output logic [P_NUM_REQ-1:0]              o_grant,
  output logic                              o_busy
);

  localparam int LP_IW = $clog2(P_NUM_REQ);
  localparam int LP_CW = $clog2(P_MAX_BURST + 1);
  localparam logic [LP_CW-1:0] LP_MAX = LP_CW'(P_MAX_BURST);
  localparam logic [P_NUM_REQ-1:0] LP_ONE = {{(P_NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_TAG  = 2'd2
  } state_t;

  state_t                  r_state;
  logic [LP_IW-1:0]        r_gidx;
  logic [LP_IW-1:0]        r_ptr;
  logic [P_NUM_REQ-1:0]    r_grant;
  logic [LP_CW-1:0]        r_cnt;

  logic                    w_any;
  logic [LP_IW-1:0]        w_next;
  logic                    w_sel_valid;
  logic [P_DATA_WIDTH-1:0] w_sel_data;
  logic                    w_xfer_acc;
  logic [LP_CW-1:0]        w_cnt_inc;
  logic                    w_release;

  // First valid requester strictly after the pointer, wrapping around.
  function automatic logic [LP_IW-1:0] f_rr_pick(input logic [LP_IW-1:0] ptr,
                                                 input logic [P_NUM_REQ-1:0] req);
    logic [LP_IW-1:0] res;
    logic             found;
    int               idx;
    res   = ptr;
    found = 1'b0;
    for (int k = 1; k <= P_NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= P_NUM_REQ) begin
        idx = idx - P_NUM_REQ;
      end else begin
        idx = idx;
      end
      if (req[idx] && !found) begin
        found = 1'b1;
        res   = LP_IW'(idx);
      end else begin
        found = found;
      end
    end
    return res;
  endfunction

  assign w_any       = |i_req_valid;
  assign w_next      = f_rr_pick(r_ptr, i_req_valid);
  assign w_sel_valid = i_req_valid[r_gidx];
  assign w_sel_data  = i_req_data[int'(r_gidx)*P_DATA_WIDTH +: P_DATA_WIDTH];
  assign w_xfer_acc  = (r_state == ST_XFER) && w_sel_valid && i_user_tx_ready;
  assign w_cnt_inc   = r_cnt + LP_CW'(1);
  // Counter never passes LP_MAX: release fires on the byte that reaches it.
  assign w_release   = w_xfer_acc && (i_req_last[r_gidx] || (w_cnt_inc == LP_MAX));

`ifdef UART_ARB_TAG_EN
  logic [7:0] w_tag;
  assign w_tag = {4'hA, 4'(r_gidx)};
`endif

  // Arbitration state machine: grant, burst count and round-robin pointer.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state <= ST_IDLE;
      r_gidx  <= '0;
      r_ptr   <= LP_IW'(P_NUM_REQ - 1);
      r_grant <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gidx  <= w_next;
            r_grant <= LP_ONE << w_next;
            r_cnt   <= '0;
`ifdef UART_ARB_TAG_EN
            r_state <= ST_TAG;
`else
            r_state <= ST_XFER;
`endif
          end
        end
`ifdef UART_ARB_TAG_EN
        ST_TAG: begin
          if (i_user_tx_ready) begin
            r_state <= ST_XFER;
          end
        end
`endif
        ST_XFER: begin
          if (w_xfer_acc) begin
            r_cnt <= w_cnt_inc;
          end
          if (w_release) begin
            r_ptr   <= r_gidx;
            r_grant <= '0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_grant <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Datapath passthrough from the registered grant; nothing driven while idle.
  always_comb begin
    o_user_tx_valid = 1'b0;
    o_user_tx_data  = '0;
    o_req_ready     = '0;
    case (r_state)
      ST_XFER: begin
        o_user_tx_valid     = w_sel_valid;
        o_user_tx_data      = w_sel_data;
        o_req_ready[r_gidx] = i_user_tx_ready;
      end
`ifdef UART_ARB_TAG_EN
      ST_TAG: begin
        o_user_tx_valid = 1'b1;
        o_user_tx_data  = P_DATA_WIDTH'(w_tag);
      end
`endif
      default: begin
        o_user_tx_valid = 1'b0;
        o_user_tx_data  = '0;
        o_req_ready     = '0;
      end
    endcase
  end

  assign o_grant = r_grant;
  assign o_busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter (4 requesters, burst limit 4).
// Tag expectations are added when UART_ARB_TAG_EN is defined.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int W = 8;
`ifdef UART_ARB_TAG_EN
  localparam int TAGX = 1;
`else
  localparam int TAGX = 0;
`endif

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   i_req_valid;
  logic [N*W-1:0] i_req_data;
  logic [N-1:0]   i_req_last;
  logic [N-1:0]   o_req_ready;
  logic           o_user_tx_valid;
  logic [W-1:0]   o_user_tx_data;
  logic           i_user_tx_ready;
  logic [N-1:0]   o_grant;
  logic           o_busy;

  uart_tx_arbiter #(.P_NUM_REQ(N), .P_DATA_WIDTH(W), .P_MAX_BURST(4)) dut (
    .S_AXI_ACLK      (clk),
    .S_AXI_ARESETN   (rst_n),
    .i_req_valid     (i_req_valid),
    .i_req_data      (i_req_data),
    .i_req_last      (i_req_last),
    .o_req_ready     (o_req_ready),
    .o_user_tx_valid (o_user_tx_valid),
    .o_user_tx_data  (o_user_tx_data),
    .i_user_tx_ready (i_user_tx_ready),
    .o_grant         (o_grant),
    .o_busy          (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] grant;
  } exp_t;

  exp_t       sbq[$];
  logic [8:0] rq[N][$];
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic load(input int r, input logic [7:0] d, input logic last);
    rq[r].push_back({last, d});
  endtask

  task automatic exp_byte(input int g, input logic [7:0] d);
    logic [3:0] one;
    one = 4'd1;
    sbq.push_back({d, one << g});
  endtask

  task automatic exp_grant(input int g);
`ifdef UART_ARB_TAG_EN
    logic [3:0] gi;
    gi = 4'(g);
    exp_byte(g, {4'hA, gi});
`endif
  endtask

  task automatic wait_byte(input logic [7:0] d, output int cyc);
    cyc = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      cyc++;
      if (rst_n && o_user_tx_valid && i_user_tx_ready && o_user_tx_data == d) return;
    end
    chk("wait_byte_timeout", {24'h0, d}, 32'hFFFF_FFFF);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 300 && sbq.size() != 0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("drain_sbq", sbq.size(), 0);
    chk("drain_idle", {31'h0, o_busy}, 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    for (int i = 0; i < N; i++) rq[i].delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Requester models: present queue heads, pop on an observed handshake.
  initial begin
    logic [N-1:0] acc;
    i_req_valid = '0;
    i_req_data  = '0;
    i_req_last  = '0;
    forever begin
      @(negedge clk);
      acc = o_req_ready & i_req_valid;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          i_req_valid[i]         = 1'b1;
          i_req_data[i*W +: W]   = rq[i][0][7:0];
          i_req_last[i]          = rq[i][0][8];
        end else begin
          i_req_valid[i]         = 1'b0;
          i_req_data[i*W +: W]   = '0;
          i_req_last[i]          = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted UART byte.
  initial begin
    exp_t       e;
    logic       prev_stall;
    logic [7:0] prev_data;
    logic [3:0] prev_grant;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_grant = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("ready_onehot0", {31'h0, $onehot0(o_req_ready)}, 32'h1);
        chk("ready_granted_only", {28'h0, o_req_ready & ~o_grant}, 32'h0);
        if (prev_stall) begin
          chk("stall_data_stable", {24'h0, o_user_tx_data}, {24'h0, prev_data});
          chk("stall_grant_stable", {28'h0, o_grant}, {28'h0, prev_grant});
        end
        if (o_user_tx_valid && i_user_tx_ready) begin
          if (sbq.size() == 0) begin
            chk("unexpected_byte", {24'h0, o_user_tx_data}, 32'hFFFF_FFFF);
          end else begin
            e = sbq.pop_front();
            chk("sb_data", {24'h0, o_user_tx_data}, {24'h0, e.data});
            chk("sb_grant", {28'h0, o_grant}, {28'h0, e.grant});
          end
        end
        prev_stall = o_user_tx_valid && !i_user_tx_ready;
        prev_data  = o_user_tx_data;
        prev_grant = o_grant;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    int         c;
    logic [0:4] pat;
    rst_n           = 1'b0;
    i_user_tx_ready = 1'b1;
    #3;
    chk("rst_grant", {28'h0, o_grant}, 32'h0);
    chk("rst_busy", {31'h0, o_busy}, 32'h0);
    chk("rst_valid", {31'h0, o_user_tx_valid}, 32'h0);
    chk("rst_data", {24'h0, o_user_tx_data}, 32'h0);
    chk("rst_ready", {28'h0, o_req_ready}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single requester, 3-byte packet.
    load(1, 8'h11, 1'b0); load(1, 8'h22, 1'b0); load(1, 8'h33, 1'b1);
    exp_grant(1); exp_byte(1, 8'h11); exp_byte(1, 8'h22); exp_byte(1, 8'h33);
    wait_byte(8'h11, c);
    wait_byte(8'h22, c); chk("t1_consec_22", c, 1);
    wait_byte(8'h33, c); chk("t1_consec_33", c, 1);
    chk("t1_grant", {28'h0, o_grant}, 32'h2);
    @(negedge clk);
    chk("t1_busy_drop", {31'h0, o_busy}, 32'h0);
    chk("t1_grant_clear", {28'h0, o_grant}, 32'h0);
    wait_drain();

    // Round-robin from reset with everyone valid.
    do_reset();
    load(0, 8'h40, 1'b0); load(0, 8'h41, 1'b1); load(0, 8'h48, 1'b0); load(0, 8'h49, 1'b1);
    load(1, 8'h50, 1'b0); load(1, 8'h51, 1'b1);
    load(2, 8'h60, 1'b0); load(2, 8'h61, 1'b1);
    load(3, 8'h70, 1'b0); load(3, 8'h71, 1'b1);
    exp_grant(0); exp_byte(0, 8'h40); exp_byte(0, 8'h41);
    exp_grant(1); exp_byte(1, 8'h50); exp_byte(1, 8'h51);
    exp_grant(2); exp_byte(2, 8'h60); exp_byte(2, 8'h61);
    exp_grant(3); exp_byte(3, 8'h70); exp_byte(3, 8'h71);
    exp_grant(0); exp_byte(0, 8'h48); exp_byte(0, 8'h49);
    wait_byte(8'h41, c);
    wait_byte(8'h50, c); chk("t2_gap_0_1", c, 2 + TAGX);
    wait_byte(8'h51, c);
    wait_byte(8'h60, c); chk("t2_gap_1_2", c, 2 + TAGX);
    wait_byte(8'h61, c);
    wait_byte(8'h70, c); chk("t2_gap_2_3", c, 2 + TAGX);
    wait_byte(8'h71, c);
    wait_byte(8'h48, c); chk("t2_gap_3_0", c, 2 + TAGX);
    wait_drain();

    // Backpressure on a req2 packet.
    @(posedge clk);
    #1 i_user_tx_ready = 1'b0;
    load(2, 8'h81, 1'b0); load(2, 8'h82, 1'b0); load(2, 8'h83, 1'b1);
    exp_grant(2); exp_byte(2, 8'h81); exp_byte(2, 8'h82); exp_byte(2, 8'h83);
    c = 0;
    while (!(o_user_tx_valid && o_grant == 4'b0100) && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("t3_grant_seen", {28'h0, o_grant}, 32'h4);
`ifdef UART_ARB_TAG_EN
    @(posedge clk); #1 i_user_tx_ready = 1'b1;
    @(posedge clk); #1 i_user_tx_ready = 1'b0;
`endif
    pat = 5'b10011;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1 i_user_tx_ready = pat[k];
      #1 chk("t3_ready_mirror", {28'h0, o_req_ready}, pat[k] ? 32'h4 : 32'h0);
    end
    @(posedge clk);
    #1 i_user_tx_ready = 1'b1;
    wait_drain();

    // Burst limit 4: req0 6-byte packet with req3 waiting.
    do_reset();
    for (int b = 0; b < 6; b++) load(0, 8'hC0 + 8'(b), b == 5);
    load(3, 8'hD0, 1'b0); load(3, 8'hD1, 1'b1);
    exp_grant(0);
    for (int b = 0; b < 4; b++) exp_byte(0, 8'hC0 + 8'(b));
    exp_grant(3); exp_byte(3, 8'hD0); exp_byte(3, 8'hD1);
    exp_grant(0); exp_byte(0, 8'hC4); exp_byte(0, 8'hC5);
    wait_byte(8'hC3, c);
    @(negedge clk);
    chk("t4_forced_release", {31'h0, o_busy}, 32'h0);
    wait_drain();

    // Asynchronous reset in the middle of a req1 packet.
    load(1, 8'hE0, 1'b0); load(1, 8'hE1, 1'b0); load(1, 8'hE2, 1'b1);
    exp_grant(1); exp_byte(1, 8'hE0);
    wait_byte(8'hE0, c);
    @(posedge clk);
    #2;
    chk("t5_inflight_data", {23'h0, o_user_tx_valid, o_user_tx_data}, 32'h1E1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", {31'h0, o_user_tx_valid}, 32'h0);
    chk("t5_rst_data", {24'h0, o_user_tx_data}, 32'h0);
    chk("t5_rst_ready", {28'h0, o_req_ready}, 32'h0);
    chk("t5_rst_grant", {28'h0, o_grant}, 32'h0);
    chk("t5_rst_busy", {31'h0, o_busy}, 32'h0);
    chk("t5_sb_empty", sbq.size(), 0);
    for (int i = 0; i < N; i++) rq[i].delete();
    load(0, 8'hF0, 1'b1); load(1, 8'hF1, 1'b1);
    exp_grant(0); exp_byte(0, 8'hF0);
    exp_grant(1); exp_byte(1, 8'hF1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
